uart_rx_param: RTL



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_rx_param.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the parametrised UART receiver.
// The FIFO holding stage is selected in uart_rx_param with UART_RX_FIFO_EN.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OVS = 16;

  localparam logic [3:0] SMP_A     = 4'd7;
  localparam logic [3:0] SMP_B     = 4'd8;
  localparam logic [3:0] SMP_C     = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample divider, one tick every DIV cycles plus a
// 4-bit tick index within the bit; restart realigns both to zero.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       restart,
  output logic       tick,
  output logic [3:0] idx
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 4'd1 : idx_q;
    if (restart) begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign tick = wrap;
  assign idx  = idx_q;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: 16x oversampled UART receiver, 2-of-3 voting, valid/ready out.
// Define UART_RX_FIFO_EN to replace the holding register with a FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = (CLK_FREQ + BAUD * OVS / 2) / (BAUD * OVS);
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic       STP_LAST = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad
    $error("uart_rx_param: illegal parameter set");
  end

  logic                 sync_q, rxs_q, rxp_q;
  rx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stp_q, stp_d;
  logic                 s7_q, s7_d, s8_q, s8_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;
  logic                 restart, tick, maj, smp9, end15, done, par_exp;
  logic [3:0]           idx;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick),
    .idx     (idx)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bit_d   = bit_q;
    stp_d   = stp_q;
    s7_d    = s7_q;
    s8_d    = s8_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    restart = 1'b0;
    done    = 1'b0;
    maj     = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
    smp9    = tick && (idx == SMP_C);
    end15   = tick && (idx == TICK_LAST);
    par_exp = (PARITY == PAR_ODD) ? ~(^data_q) : (^data_q);
    if (tick && idx == SMP_A) s7_d = rxs_q;
    if (tick && idx == SMP_B) s8_d = rxs_q;
    unique case (state_q)
      IDLE: begin
        if (rxp_q && !rxs_q) begin
          restart = 1'b1;
          state_d = START;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
          bit_d   = '0;
          stp_d   = 1'b0;
        end
      end
      START: begin
        if (smp9 && maj) state_d = IDLE;
        else if (end15) state_d = DATA;
      end
      DATA: begin
        if (smp9) data_d = {maj, data_q[DATA_BITS-1:1]};
        if (end15) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == BIT_LAST)
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
        end
      end
      PAR: begin
        if (smp9) perr_d = (maj != par_exp);
        if (end15) state_d = STOP;
      end
      STOP: begin
        if (smp9) begin
          if (!maj) ferr_d = 1'b1;
          // Complete mid-bit so a back-to-back start edge is not missed.
          if (stp_q == STP_LAST) begin
            done    = 1'b1;
            state_d = rxs_q ? IDLE : WAIT_HIGH;
          end
        end
        if (end15) stp_d = 1'b1;
      end
      WAIT_HIGH: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      rxp_q   <= 1'b1;
      state_q <= IDLE;
      data_q  <= '0;
      bit_q   <= '0;
      stp_q   <= 1'b0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= uart_rx;
      rxs_q   <= sync_q;
      rxp_q   <= rxs_q;
      state_q <= state_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      stp_q   <= stp_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy    = busy_q;
  assign overrun = ovr_q;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_BITS+1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS+1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 pop, push;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovr_d = ovr_q;
    pop   = (cnt_q != '0) && rx_ready;
    push  = done && ((cnt_q != FULL_CNT) || pop);
    if (pop) begin
      rd_d  = rd_q + 1'b1;
      ovr_d = 1'b0;
    end
    if (push) begin
      mem_d[wr_q] = {data_q, ferr_d, perr_q};
      wr_d        = wr_q + 1'b1;
    end
    if (done && !push) ovr_d = 1'b1;
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rx_valid   = (cnt_q != '0);
  assign rx_data    = mem_q[rd_q][DATA_BITS+1:2];
  assign frame_err  = mem_q[rd_q][1];
  assign parity_err = mem_q[rd_q][0];
`else
  logic [DATA_BITS-1:0] hd_q, hd_d;
  logic                 hv_q, hv_d, hf_q, hf_d, hp_q, hp_d;
  logic                 acc;

  always_comb begin
    hd_d  = hd_q;
    hv_d  = hv_q;
    hf_d  = hf_q;
    hp_d  = hp_q;
    ovr_d = ovr_q;
    acc   = hv_q && rx_ready;
    if (acc) begin
      hv_d  = 1'b0;
      ovr_d = 1'b0;
    end
    if (done) begin
      if (!hv_q || acc) begin
        hd_d = data_q;
        hf_d = ferr_d;
        hp_d = perr_q;
        hv_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      hd_q <= '0;
      hv_q <= 1'b0;
      hf_q <= 1'b0;
      hp_q <= 1'b0;
    end else begin
      hd_q <= hd_d;
      hv_q <= hv_d;
      hf_q <= hf_d;
      hp_q <= hp_d;
    end
  end

  assign rx_valid   = hv_q;
  assign rx_data    = hd_q;
  assign frame_err  = hf_q;
  assign parity_err = hp_q;
`endif

endmodule
